// File: rtl/adc_tx.sv
// Capture-and-send engine: buffers a requested number of ADC samples, then
// streams them as a framed packet (flag, page, length LB/HB, data) to the SPI transmitter.
module adc_tx #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] FLAG   = 8'h5A
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic        cmd_start,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  cmd_page,
    input  logic        cmd_abort,
    output logic        busy,
    output logic        done,
    output logic [7:0]  txd_data,
    output logic        txd_valid,
    input  logic        txd_ready
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HDR_FLAG,
        ST_HDR_PAGE,
        ST_HDR_LEN_LB,
        ST_HDR_LEN_HB,
        ST_DATA
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     len_reg, len_next;
    logic [7:0]      page_reg, page_next;
    logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
    logic [7:0]      txd_data_reg, txd_data_next;
    logic            txd_valid_reg, txd_valid_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic [7:0]      mem [0:DEPTH-1];
    logic [7:0]      rd_data_reg;
    logic            mem_we;

    logic [15:0]     cmd_len_eff;
    logic [ADDR_W:0] len_ptr;
    logic [ADDR_W:0] wr_ptr_inc;
    logic            hs;

    assign cmd_len_eff = ({1'b0, cmd_len} > DEPTH_L) ? 16'(DEPTH_L) : cmd_len;
    assign len_ptr     = (ADDR_W+1)'(len_reg);
    assign wr_ptr_inc  = wr_ptr_reg + 1'b1;
    assign hs          = txd_valid_reg & txd_ready;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign txd_data  = txd_data_reg;
    assign txd_valid = txd_valid_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            page_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            txd_data_reg  <= '0;
            txd_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            page_reg      <= page_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            txd_data_reg  <= txd_data_next;
            txd_valid_reg <= txd_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // The read port follows rd_ptr_next, so rd_data_reg always holds
    // buffer[rd_ptr_reg]: the byte to present on the next data handshake.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= adc_data;
        end
        rd_data_reg <= mem[rd_ptr_next[ADDR_W-1:0]];
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        page_next      = page_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        txd_data_next  = txd_data_reg;
        txd_valid_next = txd_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        mem_we         = 1'b0;

        if (state_reg != ST_IDLE && cmd_abort) begin
            state_next     = ST_IDLE;
            txd_valid_next = 1'b0;
            txd_data_next  = '0;
            busy_next      = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_start && !cmd_abort) begin
                        len_next    = cmd_len_eff;
                        page_next   = cmd_page;
                        wr_ptr_next = '0;
                        rd_ptr_next = '0;
                        busy_next   = 1'b1;
                        if (cmd_len_eff == 16'd0) begin
                            state_next     = ST_HDR_FLAG;
                            txd_valid_next = 1'b1;
                            txd_data_next  = FLAG;
                        end else begin
                            state_next = ST_CAPTURE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (adc_valid) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_inc;
                        if (wr_ptr_inc == len_ptr) begin
                            state_next     = ST_HDR_FLAG;
                            txd_valid_next = 1'b1;
                            txd_data_next  = FLAG;
                        end
                    end
                end

                ST_HDR_FLAG: begin
                    if (hs) begin
                        state_next    = ST_HDR_PAGE;
                        txd_data_next = page_reg;
                    end
                end

                ST_HDR_PAGE: begin
                    if (hs) begin
                        state_next    = ST_HDR_LEN_LB;
                        txd_data_next = len_reg[7:0];
                    end
                end

                ST_HDR_LEN_LB: begin
                    if (hs) begin
                        state_next    = ST_HDR_LEN_HB;
                        txd_data_next = len_reg[15:8];
                    end
                end

                ST_HDR_LEN_HB: begin
                    if (hs) begin
                        if (len_reg != 16'd0) begin
                            state_next    = ST_DATA;
                            txd_data_next = rd_data_reg;
                            rd_ptr_next   = rd_ptr_reg + 1'b1;
                        end else begin
                            state_next     = ST_IDLE;
                            txd_valid_next = 1'b0;
                            txd_data_next  = '0;
                            busy_next      = 1'b0;
                            done_next      = 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (hs) begin
                        // rd_ptr_reg == L means byte L-1 is the one just accepted
                        if (rd_ptr_reg == len_ptr) begin
                            state_next     = ST_IDLE;
                            txd_valid_next = 1'b0;
                            txd_data_next  = '0;
                            busy_next      = 1'b0;
                            done_next      = 1'b1;
                        end else begin
                            txd_data_next = rd_data_reg;
                            rd_ptr_next   = rd_ptr_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_next     = ST_IDLE;
                    txd_valid_next = 1'b0;
                    busy_next      = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_tx.md
# adc_tx

Capture-and-send block for the ADC path, the transmit counterpart of the DAC frame receiver on the SPI socket. On command it captures a requested number of 8-bit ADC samples into an internal buffer. It then emits them toward the SPI transmitter as one frame: flag `0x5A`, page byte, length LB, length HB, then the data bytes. The frame uses the same byte format the DAC side parses, so host software handles both directions with one framing routine.

## Interface
- `ADDR_W`, 10: buffer address width; depth = 2^ADDR_W samples.
- `FLAG`, 8'h5A: frame start byte.
- `clk` in 1: single system clock; all ports synchronous to it.
- `resetn` in 1: reset, synchronous, active-low.
- `adc_data` in 8: sample, valid when `adc_valid`=1 (already in `clk` domain).
- `adc_valid` in 1: sample strobe.
- `cmd_start` in 1: one-cycle pulse, begin capture+send.
- `cmd_len` in 16: requested sample count, sampled with `cmd_start`.
- `cmd_page` in 8: page byte for header, sampled with `cmd_start`.
- `cmd_abort` in 1: terminate current operation.
- `busy` out 1: high from the cycle after accepted start until return to IDLE.
- `done` out 1: one-cycle pulse, frame fully sent.
- `txd_data` out 8: byte to SPI transmitter.
- `txd_valid` out 1: `txd_data` valid.
- `txd_ready` in 1: SPI transmitter accepts byte; transfer occurs on cycle with `txd_valid`&`txd_ready`.

## Operation
- Reset values: `busy`=0, `done`=0, `txd_valid`=0, `txd_data`=8'h00, state IDLE, pointers 0. Buffer contents undefined.
- Effective length L = min(`cmd_len`, 2^ADDR_W), latched with page at start; header carries L, not `cmd_len`.
- States: IDLE, CAPTURE, HDR_FLAG, HDR_PAGE, HDR_LEN_LB, HDR_LEN_HB, DATA.
- IDLE: `cmd_start`=1 -> CAPTURE (L>0) or HDR_FLAG (L=0). Otherwise stay.
- CAPTURE: each `adc_valid` writes `adc_data` to buffer[wr_ptr], wr_ptr+1. The write of sample L moves to HDR_FLAG next cycle. `adc_valid` outside CAPTURE is ignored.
- Header states: present FLAG, page, L[7:0], L[15:8] in order. Each advances on handshake.
- HDR_LEN_HB handshake: -> DATA if L>0, else finish.
- DATA: bytes buffer[0..L-1] in capture order, one per handshake. The last handshake finishes the frame.
- Finish: `done`=1 and `busy`=0 on the cycle after the final handshake; state IDLE.
- `cmd_start` while `busy` is ignored.
- `cmd_abort` in any non-IDLE state -> IDLE next cycle: `txd_valid`=0, `busy`=0, no `done`. The frame is truncated; the host resyncs on FLAG.
- `cmd_abort` and `cmd_start` in the same IDLE cycle: abort wins, start dropped.
- `resetn` low mid-frame: same end result as abort, via reset values at the next edge.
- Length counter and address width: L is 16-bit. Read pointer is ADDR_W+1 bits wide so L = 2^ADDR_W is reachable without wrap ambiguity.

## Timing
- `cmd_start` at cycle T -> `busy`=1 at T+1.
- Last capture write at cycle C -> `txd_valid`=1, `txd_data`=FLAG at C+1.
- For L=0 with a start at T: FLAG is presented at T+1.
- Once asserted, `txd_valid` stays high until frame end. There are no bubbles between header and data.
- With `txd_ready` held high, the frame occupies exactly 4+L consecutive valid cycles. The buffer is read synchronously, so the next byte must be prefetched.
- `txd_data` is stable while `txd_valid`=1 and `txd_ready`=0.
- `txd_data` changes only after a handshake, or on abort/reset.
- `done` is exactly one cycle wide, coincident with `busy` falling.

## Test plan
- L=4, page 0x12, samples 0x10..0x13, `txd_ready`=1 -> bytes 5A 12 04 00 10 11 12 13 on 8 consecutive cycles, then `done` pulse, `busy`=0.
- Same frame with `txd_ready` pseudo-random 50% -> identical byte sequence, no duplicates or drops, `txd_data` stable during stalls.
- `cmd_len`=0, page 0xA5 -> 5A A5 00 00, no CAPTURE, `adc_valid` pulses ignored, `done` after 4th byte.
- `ADDR_W`=10, `cmd_len`=0x0500, ramp samples -> header 5A pg 00 04, 1024 data bytes in ramp order, no wrap.
- `cmd_abort` during DATA, then separately `resetn` low during HDR_PAGE -> `txd_valid`=0 and `busy`=0 next cycle, no `done`; a following start with L=2 produces a correct full frame.
- `cmd_start` pulsed during CAPTURE and DATA -> ignored, current frame unaffected.
- Simultaneous `cmd_start`+`cmd_abort` in IDLE -> stays IDLE.
